apb_soc_ctrl: RTL and testbench

Parametrised successor of the PULPino SoC control APB slave. It holds the pad-mux, clock-gate, boot-address, status and per-pad configuration registers for a configurable pad count. It adds three things the previous block lacked: a sticky configuration lock, PSLVERR reporting, and a core-release sequencer with a programmable fetch-enable delay and a software core-reset pulse. It sits on the peripheral APB bus next to the other 4 KB slaves and drives the pad frame and the core's boot/fetch inputs.

---
 rtl/apb_soc_ctrl_pkg.sv | 24 ++
 rtl/soc_fetch_seq.sv | 64 ++++++
 rtl/apb_soc_ctrl.sv | 139 +++++++++++++
 tb/tb_apb_soc_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_soc_ctrl_pkg.sv
// Shared definitions for the SoC control APB slave: register word indices,
// lock key, block version and the core-release sequencer states.
package apb_soc_ctrl_pkg;

  localparam logic [5:0] W_PAD_MUX  = 6'd0;
  localparam logic [5:0] W_CLK_GATE = 6'd1;
  localparam logic [5:0] W_BOOT_ADR = 6'd2;
  localparam logic [5:0] W_FETCH_EN = 6'd3;
  localparam logic [5:0] W_INFO     = 6'd4;
  localparam logic [5:0] W_STATUS   = 6'd5;
  localparam logic [5:0] W_LOCK     = 6'd6;
  localparam logic [5:0] W_CORE_RST = 6'd7;
  localparam logic [5:0] W_PADCFG   = 6'd16;

  localparam logic [31:0] LOCK_KEY = 32'hC0DE_1A7E;
  localparam logic [7:0]  VERSION  = 8'h03;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/soc_fetch_seq.sv
// Core-release sequencer: programmable fetch-enable delay plus a retriggerable
// core soft-reset pulse that holds the sequencer idle while it is high.
module soc_fetch_seq
  import apb_soc_ctrl_pkg::*;
#(
  parameter int unsigned RELEASE_DLY = 16,
  parameter int unsigned RST_PULSE   = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic         rst_trig_i,
  output logic         fetch_en_o,
  output logic         core_rst_o,
  output fetch_state_e state_o
);

  fetch_state_e state_q;
  logic [15:0]  dly_q;
  logic [7:0]   pulse_q, pulse_d;

  always_comb begin
    pulse_d = pulse_q;
    if (rst_trig_i) begin
      pulse_d = 8'(RST_PULSE);
    end else if (pulse_q != '0) begin
      pulse_d = pulse_q - 8'd1;
    end
  end

  // req_i and pulse_d are next-state values, so the edge that commits a
  // request (or ends the pulse) is already the DELAY entry edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dly_q   <= '0;
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
      if (pulse_d != '0 || !req_i) begin
        state_q <= IDLE;
        dly_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= DELAY;
            dly_q   <= 16'(RELEASE_DLY);
          end
          DELAY: begin
            if (dly_q == '0) state_q <= RUN;
            else             dly_q   <= dly_q - 16'd1;
          end
          RUN:     state_q <= RUN;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign fetch_en_o = (state_q == RUN);
  assign core_rst_o = (pulse_q != '0);
  assign state_o    = state_q;

endmodule

// File: rtl/apb_soc_ctrl.sv
// SoC control APB slave: pad mux/config, clock gates, boot address, status,
// sticky configuration lock with PSLVERR, and the core-release sequencer.
module apb_soc_ctrl
  import apb_soc_ctrl_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter logic [31:0] BOOT_ADDR      = 32'h8000,
  parameter int unsigned N_PADS         = 32,
  parameter int unsigned PAD_CFG_W      = 6,
  parameter int unsigned RELEASE_DLY    = 16,
  parameter int unsigned RST_PULSE      = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [APB_ADDR_WIDTH-1:0]     PADDR,
  input  logic [31:0]                   PWDATA,
  input  logic                          PWRITE,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  output logic [31:0]                   PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [N_PADS*PAD_CFG_W-1:0]   pad_cfg_o,
  output logic [N_PADS-1:0]             pad_mux_o,
  output logic [31:0]                   clk_gate_o,
  output logic [31:0]                   boot_addr_o,
  output logic                          fetch_en_o,
  output logic                          core_rst_o,
  output logic                          locked_o
);

  localparam int unsigned N_CFG_WORDS = N_PADS / 4;

  logic [5:0]  word;
  logic        access, wr, rd, padcfg_hit, mapped, cfg_reg, err, we, rst_trig;
  logic        req_q, req_d, lock_q;
  logic [N_PADS-1:0]                  pad_mux_q;
  logic [31:0]                        clk_gate_q, boot_q;
  logic [1:0]                         status_q;
  logic [N_PADS-1:0][PAD_CFG_W-1:0]   pad_cfg_q;
  fetch_state_e                       seq_state;
  logic                               unused_paddr;

  assign word         = PADDR[7:2];
  assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:8], PADDR[1:0]};
  assign access       = PSEL & PENABLE;
  assign wr           = access & PWRITE;
  assign rd           = access & ~PWRITE;

  assign padcfg_hit = (word >= W_PADCFG) && (word < W_PADCFG + 6'(N_CFG_WORDS));
  assign mapped     = (word <= W_CORE_RST) || padcfg_hit;
  assign cfg_reg    = (word == W_PAD_MUX) || (word == W_CLK_GATE) ||
                      (word == W_BOOT_ADR) || padcfg_hit;

  always_comb begin
    err = 1'b0;
    if (!mapped) begin
      err = 1'b1;
    end else if (PWRITE) begin
      if (word == W_INFO)                                      err = 1'b1;
      else if (word == W_LOCK && !lock_q && PWDATA != LOCK_KEY) err = 1'b1;
      else if (cfg_reg && lock_q)                              err = 1'b1;
    end
  end

  assign PSLVERR  = access & err;
  assign PREADY   = 1'b1;
  assign we       = wr & ~err;
  assign rst_trig = we && (word == W_CORE_RST) && PWDATA[0];
  assign req_d    = (we && word == W_FETCH_EN) ? PWDATA[0] : req_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pad_mux_q  <= '0;
      clk_gate_q <= '1;
      boot_q     <= BOOT_ADDR;
      status_q   <= 2'b11;
      lock_q     <= 1'b0;
      req_q      <= 1'b0;
      pad_cfg_q  <= '0;
    end else begin
      req_q <= req_d;
      if (we) begin
        case (word)
          W_PAD_MUX:  pad_mux_q  <= PWDATA[N_PADS-1:0];
          W_CLK_GATE: clk_gate_q <= PWDATA;
          W_BOOT_ADR: boot_q     <= PWDATA;
          W_STATUS:   status_q   <= PWDATA[1:0];
          W_LOCK:     lock_q     <= 1'b1;
          default:    ;
        endcase
        for (int unsigned k = 0; k < N_PADS; k++) begin
          if (word == W_PADCFG + 6'(k / 4))
            pad_cfg_q[k] <= PWDATA[8*(k%4) +: PAD_CFG_W];
        end
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      case (word)
        W_PAD_MUX:  PRDATA = 32'(pad_mux_q);
        W_CLK_GATE: PRDATA = clk_gate_q;
        W_BOOT_ADR: PRDATA = boot_q;
        W_FETCH_EN: PRDATA = {28'b0, core_rst_o, 2'(seq_state), req_q};
        W_INFO:     PRDATA = {12'b0, 4'(PAD_CFG_W), 8'(N_PADS), VERSION};
        W_STATUS:   PRDATA = {30'b0, status_q};
        W_LOCK:     PRDATA = {31'b0, lock_q};
        default:    ;
      endcase
      for (int unsigned k = 0; k < N_PADS; k++) begin
        if (word == W_PADCFG + 6'(k / 4))
          PRDATA[8*(k%4) +: PAD_CFG_W] = pad_cfg_q[k];
      end
    end
  end

  soc_fetch_seq #(
    .RELEASE_DLY (RELEASE_DLY),
    .RST_PULSE   (RST_PULSE)
  ) u_seq (
    .clk_i      (HCLK),
    .rst_i      (HRESET),
    .req_i      (req_d),
    .rst_trig_i (rst_trig),
    .fetch_en_o (fetch_en_o),
    .core_rst_o (core_rst_o),
    .state_o    (seq_state)
  );

  assign pad_cfg_o   = pad_cfg_q;
  assign pad_mux_o   = pad_mux_q;
  assign clk_gate_o  = clk_gate_q;
  assign boot_addr_o = boot_q;
  assign locked_o    = lock_q;

endmodule

// File: tb/tb_apb_soc_ctrl.sv
// Scoreboard bench for apb_soc_ctrl: driver pushes expected APB responses from
// an event-timestamp model; a negedge monitor pops and compares every access.
module tb_apb_soc_ctrl;

  localparam int unsigned NP   = 32;
  localparam int unsigned CW   = 6;
  localparam int unsigned DLY  = 4;
  localparam int unsigned PUL  = 8;
  localparam logic [31:0] BOOT = 32'h8000;
  localparam logic [31:0] KEY  = 32'hC0DE_1A7E;
  localparam logic [7:0]  CMSK = 8'h3F;

  logic              HCLK = 1'b0, HRESET = 1'b1;
  logic [11:0]       PADDR = '0;
  logic [31:0]       PWDATA = '0;
  logic              PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0]       PRDATA;
  logic              PREADY, PSLVERR;
  logic [NP*CW-1:0]  pad_cfg_o;
  logic [NP-1:0]     pad_mux_o;
  logic [31:0]       clk_gate_o, boot_addr_o;
  logic              fetch_en_o, core_rst_o, locked_o;

  apb_soc_ctrl #(
    .APB_ADDR_WIDTH (12),
    .BOOT_ADDR      (BOOT),
    .N_PADS         (NP),
    .PAD_CFG_W      (CW),
    .RELEASE_DLY    (DLY),
    .RST_PULSE      (PUL)
  ) dut (
    .HCLK (HCLK), .HRESET (HRESET), .PADDR (PADDR), .PWDATA (PWDATA),
    .PWRITE (PWRITE), .PSEL (PSEL), .PENABLE (PENABLE), .PRDATA (PRDATA),
    .PREADY (PREADY), .PSLVERR (PSLVERR), .pad_cfg_o (pad_cfg_o),
    .pad_mux_o (pad_mux_o), .clk_gate_o (clk_gate_o), .boot_addr_o (boot_addr_o),
    .fetch_en_o (fetch_en_o), .core_rst_o (core_rst_o), .locked_o (locked_o)
  );

  always #5 HCLK = ~HCLK;

  int unsigned cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  logic [32:0] exp_q[$];

  // Reference model: register contents plus edge timestamps of req and pulse.
  logic [31:0] m_mux, m_gate, m_boot;
  logic [1:0]  m_status;
  bit          m_lock, m_req;
  logic [7:0]  m_cfg [NP];
  int unsigned m_req_edge, m_pend;

  function automatic logic [1:0] m_state(input int unsigned e);
    int unsigned arm;
    arm = (m_req_edge > m_pend) ? m_req_edge : m_pend;
    if (!m_req || e < m_pend) return 2'd0;
    if (e >= arm + DLY + 1)   return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [32:0] m_resp(input logic [11:0] a, input bit w, input logic [31:0] d);
    int unsigned wi;
    bit mapped, cfg, err;
    logic [31:0] rdv;
    wi = {26'b0, a[7:2]};
    mapped = (wi <= 7) || (wi >= 16 && wi < 16 + NP/4);
    cfg = (wi <= 2) || (wi >= 16);
    err = !mapped || (w && wi == 4) || (w && wi == 6 && !m_lock && d != KEY) ||
          (w && mapped && m_lock && cfg);
    rdv = '0;
    if (!w && mapped) begin
      case (wi)
        0: rdv = m_mux;
        1: rdv = m_gate;
        2: rdv = m_boot;
        3: rdv = {28'b0, (cyc < m_pend), m_state(cyc), m_req};
        4: rdv = 32'h0006_2003;
        5: rdv = {30'b0, m_status};
        6: rdv = {31'b0, m_lock};
        7: rdv = '0;
        default: for (int b = 0; b < 4; b++) rdv[8*b +: 8] = m_cfg[4*(wi-16) + b];
      endcase
    end
    return {err, rdv};
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] d, input int unsigned e);
    int unsigned wi;
    wi = {26'b0, a[7:2]};
    case (wi)
      0: m_mux = d;
      1: m_gate = d;
      2: m_boot = d;
      3: if (!d[0]) m_req = 0; else if (!m_req) begin m_req = 1; m_req_edge = e; end
      5: m_status = d[1:0];
      6: m_lock = 1;
      7: if (d[0]) m_pend = e + PUL;
      default: if (wi >= 16) for (int b = 0; b < 4; b++) m_cfg[4*(wi-16) + b] = d[8*b +: 8] & CMSK;
    endcase
  endtask

  task automatic m_reset();
    m_mux = '0; m_gate = '1; m_boot = BOOT; m_status = 2'b11;
    m_lock = 0; m_req = 0; m_req_edge = 0; m_pend = 0;
    for (int k = 0; k < NP; k++) m_cfg[k] = '0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    n_cmp++;
    if (act !== exv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exv);
    end
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge HCLK); #1; end
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    m_reset();
    HRESET = 1'b0;
  endtask

  task automatic apb(input logic [11:0] a, input bit w, input logic [31:0] d);
    logic [32:0] r;
    PADDR = a; PWRITE = w; PWDATA = d; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    r = m_resp(a, w, d);
    exp_q.push_back(r);
    @(posedge HCLK); #1;
    if (w && !r[32]) m_write(a, d, cyc);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Monitor: APB responses from the scoreboard queue, sideband outputs from the model.
  logic [32:0]      mon_r;
  logic [NP*CW-1:0] mon_cfg;
  always @(negedge HCLK) begin
    if (!HRESET) begin
      if (PSEL && PENABLE) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL apb_resp: access with no expected entry, got err=%0b data=%0h", PSLVERR, PRDATA);
        end else begin
          mon_r = exp_q.pop_front();
          if ({PSLVERR, PRDATA} !== mon_r || PREADY !== 1'b1) begin
            n_bad++;
            $display("FAIL apb_resp @%0h: got err=%0b data=%0h ready=%0b expected err=%0b data=%0h ready=1",
                     PADDR, PSLVERR, PRDATA, PREADY, mon_r[32], mon_r[31:0]);
          end
        end
      end else begin
        n_cmp++;
        if (PRDATA !== '0 || PSLVERR !== 1'b0) begin
          n_bad++;
          $display("FAIL apb_idle: got err=%0b data=%0h expected err=0 data=0", PSLVERR, PRDATA);
        end
      end
      n_cmp++;
      if ({fetch_en_o, core_rst_o, locked_o} !== {m_state(cyc) == 2'd2, cyc < m_pend, m_lock}) begin
        n_bad++;
        $display("FAIL ctrl_out @edge %0d: got fetch=%0b rst=%0b lock=%0b expected fetch=%0b rst=%0b lock=%0b",
                 cyc, fetch_en_o, core_rst_o, locked_o, m_state(cyc) == 2'd2, cyc < m_pend, m_lock);
      end
      for (int k = 0; k < NP; k++) mon_cfg[k*CW +: CW] = m_cfg[k][CW-1:0];
      n_cmp++;
      if ({pad_mux_o, clk_gate_o, boot_addr_o, pad_cfg_o} !== {m_mux[NP-1:0], m_gate, m_boot, mon_cfg}) begin
        n_bad++;
        $display("FAIL cfg_out: got mux=%0h gate=%0h boot=%0h cfg=%0h expected mux=%0h gate=%0h boot=%0h cfg=%0h",
                 pad_mux_o, clk_gate_o, boot_addr_o, pad_cfg_o, m_mux, m_gate, m_boot, mon_cfg);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi;
    bit seen;
    logic [7:0] pads [4];
    int unsigned wsel;
    logic [11:0] a;
    logic [31:0] d;
    bit w;

    m_reset();
    do_reset();

    // Reset values of every register, then a write to each RW register.
    for (int i = 0; i < 8; i++) apb(12'(4*i), 1'b0, '0);
    chk("info_const", m_resp(12'h010, 1'b0, '0) == {1'b0, 32'h0006_2003}, 32'd1);

    apb(12'h040, 1'b1, 32'h3F2A_153F);
    apb(12'h040, 1'b0, '0);
    pads[0] = 8'h3F; pads[1] = 8'h15; pads[2] = 8'h2A; pads[3] = 8'h3F;
    for (int k = 0; k < 4; k++) chk("pad_cfg_slice", 32'(pad_cfg_o[k*CW +: CW]), 32'(pads[k]));
    apb(12'h040, 1'b1, 32'hFFFF_FFFF);
    apb(12'h040, 1'b0, '0);
    apb(12'h05C, 1'b1, 32'h0102_0304);
    apb(12'h05C, 1'b0, '0);

    // Randomised traffic over mapped, unmapped and aliased addresses.
    for (int t = 0; t < 300; t++) begin
      wsel = $urandom_range(0, 27);
      a = {4'($urandom), 6'(wsel), 2'($urandom)};
      w = ($urandom_range(0, 1) == 1);
      d = $urandom;
      if (wsel == 6 && $urandom_range(0, 3) == 0) d = KEY;
      apb(a, w, d);
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) idle($urandom_range(4, 14));
      if ($urandom_range(0, 29) == 0) do_reset();
    end

    // Fetch-enable timing from the committing write edge.
    do_reset();
    apb(12'h00C, 1'b1, 32'h1);
    n = 0;
    for (int i = 0; i < 20; i++) begin idle(1); n++; if (fetch_en_o) break; end
    chk("fetch_rise_edges", 32'(n), 32'd5);
    apb(12'h00C, 1'b1, 32'h0);
    chk("fetch_fall", 32'(fetch_en_o), 32'd0);
    apb(12'h00C, 1'b1, 32'h1);
    idle(8);
    apb(12'h00C, 1'b0, '0);

    // Core-reset pulse while running, retriggered in its third cycle.
    apb(12'h01C, 1'b1, 32'h1);
    hi = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge HCLK);
          if (core_rst_o) hi++; else break;
        end
      end
      begin
        idle(1);
        apb(12'h01C, 1'b1, 32'h1);
      end
    join
    chk("rst_pulse_len", 32'(hi), 32'd11);
    n = 0;
    for (int i = 0; i < 30; i++) begin @(posedge HCLK); #1; n++; if (fetch_en_o) break; end
    chk("fetch_after_pulse", 32'(n), 32'd5);

    // Reset in the middle of the release delay.
    apb(12'h00C, 1'b1, 32'h0);
    apb(12'h00C, 1'b1, 32'h1);
    idle(2);
    do_reset();
    seen = 0;
    for (int i = 0; i < 20; i++) begin idle(1); if (fetch_en_o) seen = 1; end
    chk("fetch_after_reset", 32'(seen), 32'd0);

    // Unmapped PADCFG word and write to read-only INFO.
    apb(12'h060, 1'b0, '0);
    apb(12'h010, 1'b1, 32'hDEAD_BEEF);
    apb(12'h010, 1'b0, '0);

    // Lock behaviour.
    apb(12'h018, 1'b1, 32'h1234_5678);
    apb(12'h018, 1'b1, KEY);
    apb(12'h008, 1'b1, 32'h1000);
    chk("boot_locked", boot_addr_o, BOOT);
    chk("locked_o", 32'(locked_o), 32'd1);
    apb(12'h014, 1'b1, 32'h0);
    apb(12'h014, 1'b0, '0);
    apb(12'h018, 1'b1, 32'h0);
    apb(12'h044, 1'b1, 32'h1111_1111);
    apb(12'h000, 1'b1, 32'hFFFF_FFFF);
    apb(12'h018, 1'b0, '0);
    idle(2);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
